// File: rtl/dmem_arbiter.sv
// Shares the single DMEM port between the CPU data port (priority, combinational)
// and an auxiliary req/gnt requester. Optional counters via `ARB_STATS_EN`.
//
// state | meaning
// IDLE  | CPU owns DMEM; aux gets cycles where cpu_cs is low
// FORCE | one-cycle CPU stall; DMEM slot handed to the waiting aux request
module dmem_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_r,
  input  logic        cpu_w,
  input  logic [10:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_bits,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [10:0] aux_addr,
  input  logic [31:0] aux_wdata,
  input  logic [1:0]  aux_bits,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        dm_cs,
  output logic        dm_r,
  output logic        dm_w,
  output logic [10:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [1:0]  dm_bits,
  input  logic [31:0] dm_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stat_grants,
  output logic [15:0] stat_forced
`endif
);

  typedef enum logic {IDLE, FORCE} state_t;

  localparam bit              FORCE_EN  = (MAX_WAIT != 0);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_force;
  logic             aux_sel;
  logic             force_next;

  assign in_force = (state == FORCE);

  // In FORCE the port belongs to aux even if it dropped its request, so a
  // pending CPU write can never slip through during the stall cycle.
  always_comb begin
    aux_gnt = in_force ? aux_req : (aux_req & ~cpu_cs);
    aux_sel = in_force | aux_gnt;
    if (aux_sel) begin
      dm_cs    = aux_req;
      dm_r     = aux_req & ~aux_we;
      dm_w     = aux_req & aux_we;
      dm_addr  = aux_addr;
      dm_wdata = aux_wdata;
      dm_bits  = aux_bits;
    end else begin
      dm_cs    = cpu_cs;
      dm_r     = cpu_r;
      dm_w     = cpu_w;
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_bits  = cpu_bits;
    end
    cpu_rdata = in_force ? 32'h0 : dm_rdata;
  end

  assign force_next = FORCE_EN && !in_force && aux_req && !aux_gnt &&
                      (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cpu_stall  <= 1'b0;
      aux_rvalid <= 1'b0;
      aux_rdata  <= 32'h0;
    end else begin
      aux_rvalid <= aux_gnt & ~aux_we;
      if (aux_gnt && !aux_we)
        aux_rdata <= dm_rdata;
      case (state)
        IDLE: begin
          if (force_next) begin
            state     <= FORCE;
            cpu_stall <= 1'b1;
            wait_cnt  <= WAIT_MAX;
          end else begin
            cpu_stall <= 1'b0;
            if (aux_req && !aux_gnt) begin
              if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
              wait_cnt <= '0;
            end
          end
        end
        FORCE: begin
          state     <= IDLE;
          cpu_stall <= 1'b0;
          wait_cnt  <= '0;
        end
        default: begin
          state     <= IDLE;
          cpu_stall <= 1'b0;
          wait_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk_in) begin
    if (reset) begin
      stat_grants <= 16'h0;
      stat_forced <= 16'h0;
    end else begin
      if (aux_gnt && stat_grants != 16'hFFFF)
        stat_grants <= stat_grants + 16'h1;
      if (force_next && stat_forced != 16'hFFFF)
        stat_forced <= stat_forced + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model and a reference copy of DMEM.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 8;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_r, cpu_w;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_bits;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        aux_req, aux_we;
  logic [10:0] aux_addr;
  logic [31:0] aux_wdata;
  logic [1:0]  aux_bits;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] aux_rdata;
  logic        dm_cs, dm_r, dm_w;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_bits;
  logic [31:0] dm_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_grants, stat_forced;
`endif

  always #5 clk_in = ~clk_in;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_bits(cpu_bits), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_bits(aux_bits), .aux_gnt(aux_gnt),
    .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_bits(dm_bits), .dm_rdata(dm_rdata)
`ifdef ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_forced(stat_forced)
`endif
  );

  // DMEM: combinational read, write on the rising edge
  logic [31:0] dmem [0:511];
  assign dm_rdata = dmem[dm_addr[10:2]];
  always @(posedge clk_in)
    if (dm_cs && dm_w) dmem[dm_addr[10:2]] <= dm_wdata;

  logic [31:0] mem_ref [0:511];
  bit          m_forced;
  int          m_waited;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  int          m_grants, m_forces;
  bit          chk_en;
  bit          last_gnt;
  logic [31:0] last_cpu_rdata;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called one time unit after a rising edge with inputs already applied.
  task automatic step();
    bit          exp_gnt;
    int          aw, cw;
    logic [31:0] rd;
    #3;
    exp_gnt = m_forced ? aux_req : (aux_req & ~cpu_cs);
    aw = int'(aux_addr[10:2]);
    cw = int'(cpu_addr[10:2]);
    last_gnt = aux_gnt;
    last_cpu_rdata = cpu_rdata;
    if (chk_en) begin
      check("aux_gnt", aux_gnt, exp_gnt);
      check("cpu_stall", cpu_stall, m_forced);
      check("aux_rvalid", aux_rvalid, m_rvalid);
      check("aux_rdata", aux_rdata, m_rdata);
      if (m_forced || exp_gnt) begin
        check("dm_ctl_aux", {dm_cs, dm_r, dm_w},
              {aux_req, aux_req & ~aux_we, aux_req & aux_we});
        if (aux_req) begin
          check("dm_addr_aux", dm_addr, aux_addr);
          check("dm_wdata_aux", dm_wdata, aux_wdata);
          check("dm_bits_aux", dm_bits, aux_bits);
        end
      end else begin
        check("dm_ctl_cpu", {dm_cs, dm_r, dm_w}, {cpu_cs, cpu_r, cpu_w});
        check("dm_addr_cpu", dm_addr, cpu_addr);
        check("dm_wdata_cpu", dm_wdata, cpu_wdata);
        check("dm_bits_cpu", dm_bits, cpu_bits);
      end
      if (m_forced)
        check("cpu_rdata_force", cpu_rdata, 32'h0);
      else if (cpu_cs && cpu_r && !exp_gnt)
        check("cpu_rdata", cpu_rdata, mem_ref[cw]);
    end
    @(posedge clk_in);
    rd = mem_ref[aw];
    if (exp_gnt && aux_we)
      mem_ref[aw] = aux_wdata;
    else if (!m_forced && !exp_gnt && cpu_cs && cpu_w)
      mem_ref[cw] = cpu_wdata;
    if (reset) begin
      m_forced = 0; m_waited = 0; m_rvalid = 0; m_rdata = 32'h0;
      m_grants = 0; m_forces = 0;
    end else begin
      m_rvalid = exp_gnt && !aux_we;
      if (m_rvalid) m_rdata = rd;
      if (exp_gnt && m_grants < 65535) m_grants++;
      if (m_forced) begin
        m_forced = 0;
        m_waited = 0;
      end else if (aux_req && !exp_gnt) begin
        m_waited++;
        if (MAX_WAIT != 0 && m_waited == MAX_WAIT) begin
          m_forced = 1;
          m_waited = 0;
          if (m_forces < 65535) m_forces++;
        end
      end else begin
        m_waited = 0;
      end
    end
    #1;
  endtask

  task automatic quiet();
    cpu_cs = 0; cpu_r = 0; cpu_w = 0; aux_req = 0; aux_we = 0;
  endtask

  initial begin
    int stalls, first_stall;
    n_tests = 0; n_fail = 0; chk_en = 0;
    m_forced = 0; m_waited = 0; m_rvalid = 0; m_rdata = 0; m_grants = 0; m_forces = 0;
    for (int i = 0; i < 512; i++) begin
      dmem[i] = 32'(i) * 32'h9E37_79B9;
      mem_ref[i] = dmem[i];
    end
    dmem[4] = 32'hDEAD_BEEF;
    mem_ref[4] = 32'hDEAD_BEEF;
    reset = 1; quiet();
    cpu_addr = 11'h100; cpu_wdata = 32'h1111_2222; cpu_bits = 2'b01;
    aux_addr = 11'h104; aux_wdata = 32'h3333_4444; aux_bits = 2'b10;
    #1;

    // reset with inputs active; writes held off until state is known
    cpu_cs = 1; cpu_r = 1; aux_req = 1;
    step();
    chk_en = 1;
    cpu_w = 1; aux_we = 1;
    step();
    reset = 0; quiet();
    step();

    // aux read of preloaded word while CPU idle
    aux_req = 1; aux_we = 0; aux_addr = 11'h010;
    step();
    quiet();
    step();
    check("aux_read_deadbeef", aux_rdata, 32'hDEAD_BEEF);

    // continuous CPU traffic starves aux until a stall slot is forced
    cpu_cs = 1; cpu_r = 1; cpu_addr = 11'h040;
    aux_req = 1; aux_we = 0; aux_addr = 11'h010;
    stalls = 0; first_stall = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_stall) begin
        stalls++;
        if (first_stall < 0) first_stall = i;
      end
    end
    check("stall_count", 32'(stalls), 32'd2);
    check("first_stall_idx", 32'(first_stall), 32'd7);
    quiet();
    step();

    // simultaneous CPU and aux writes: CPU first, aux next idle cycle
    cpu_cs = 1; cpu_w = 1; cpu_addr = 11'h020; cpu_wdata = 32'h1234_5678;
    aux_req = 1; aux_we = 1; aux_addr = 11'h024; aux_wdata = 32'hAAAA_5555;
    step();
    check("aux_wait_cpu", last_gnt, 1'b0);
    cpu_cs = 0; cpu_w = 0;
    step();
    check("aux_idle_gnt", last_gnt, 1'b1);
    quiet();
    cpu_cs = 1; cpu_r = 1; cpu_addr = 11'h020;
    step();
    check("readback_cpu_wr", last_cpu_rdata, 32'h1234_5678);
    cpu_addr = 11'h024;
    step();
    check("readback_aux_wr", last_cpu_rdata, 32'hAAAA_5555);

    // reset asserted during a FORCE cycle
    cpu_cs = 1; cpu_r = 1; aux_req = 1; aux_we = 0; aux_addr = 11'h010;
    for (int i = 0; i < 20 && !m_forced; i++) step();
    check("force_reached", m_forced, 1'b1);
    reset = 1;
    step();
    reset = 0; quiet();
    step();
    check("rst_force_stall", cpu_stall, 1'b0);
    check("rst_force_rvalid", aux_rvalid, 1'b0);

    // randomized traffic; aux normally holds its request until granted
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      cpu_cs = ($urandom_range(0, 9) < 7);
      cpu_r = $urandom_range(0, 1) == 1;
      cpu_w = !cpu_r && ($urandom_range(0, 1) == 1);
      cpu_addr = 11'($urandom_range(0, 15) * 4);
      cpu_wdata = $urandom;
      cpu_bits = 2'($urandom_range(0, 3));
      if (!aux_req || last_gnt || $urandom_range(0, 15) == 0) begin
        aux_req = ($urandom_range(0, 3) != 0);
        aux_we = $urandom_range(0, 1) == 1;
        aux_addr = 11'($urandom_range(0, 15) * 4);
        aux_wdata = $urandom;
        aux_bits = 2'($urandom_range(0, 3));
      end
      step();
    end
    reset = 0; quiet();
    step();
`ifdef ARB_STATS_EN
    check("stat_grants", stat_grants, 16'(m_grants));
    check("stat_forced", stat_forced, 16'(m_forces));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
